// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by fetch_unit and fetch_fifo.
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // Byte distance between consecutive sequential fetches.
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // Fetch control FSM states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } fetch_state_e;

  // One fetch buffer entry: the instruction word and the byte address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer of DEPTH entries (DEPTH 2..4) with push, pop and flush.
// Flush has priority over push/pop. A push while full is accepted only together
// with a pop, which frees the slot being written.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Requests are qualified locally so the buffer can never under- or overflow.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q < CW'(DEPTH)) || pop_ok);

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop_ok) begin
        head_d = ptr_inc(head_q);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, BOOT/RUN/TRAP control FSM and a fetch
// buffer (fetch_fifo) toward decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a redirect to a target
// with nonzero low bits flushes, raises sticky o_Misalign and parks in TRAP.
// Without it the target's low two bits are forced to zero.
//
// Handshake toward decode: an entry transfers on a rising edge where
// o_Valid && i_Ready; o_Instr/o_PC hold steady while o_Valid && !i_Ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  output logic [XLEN-1:0]    o_IMemAddr,
  input  logic [INSTR_W-1:0] i_IMemInstr,
  input  logic               i_Redirect,
  input  logic [XLEN-1:0]    i_RedirectPC,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [INSTR_W-1:0] o_Instr,
  output logic [XLEN-1:0]    o_PC,
  output logic               o_Misalign,
  output fetch_state_e       o_DbgState
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e  state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fetch_entry;
  logic          pop_req;
  logic          fetch_en;
  logic          redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic          redirect_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign redirect_pc  = i_RedirectPC;
  assign redirect_bad = |i_RedirectPC[1:0];

  // Sticky misalign flag: updated only by an accepted redirect.
  always_comb begin
    misalign_d = misalign_q;
    if (redirect_en) begin
      misalign_d = redirect_bad;
    end
  end

  // Misalign flag register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign o_Misalign = misalign_q;
`else
  logic unused_redirect_lsbs;

  assign redirect_pc          = {i_RedirectPC[XLEN-1:2], 2'b00};
  assign redirect_bad         = 1'b0;
  assign unused_redirect_lsbs = ^i_RedirectPC[1:0];
  assign o_Misalign           = 1'b0;
`endif

  // Decode takes the head entry whenever one is presented and it is ready.
  assign pop_req = (fifo_count != '0) && i_Ready;

  // FSM state register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: BOOT always moves on; redirects pick RUN or TRAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_TRAP: begin
        if (i_Redirect) begin
          state_d = redirect_bad ? ST_TRAP : ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // FSM outputs: redirect wins over fetch; only RUN fetches, and only with room.
  always_comb begin
    fetch_en    = 1'b0;
    redirect_en = 1'b0;
    case (state_q)
      ST_RUN: begin
        redirect_en = i_Redirect;
        fetch_en    = !i_Redirect && ((fifo_count < CW'(DEPTH)) || pop_req);
      end
      ST_TRAP: begin
        redirect_en = i_Redirect;
      end
      default: begin
        fetch_en    = 1'b0;
        redirect_en = 1'b0;
      end
    endcase
  end

  // Next PC: redirect target, else sequential advance on a fetch, else hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (fetch_en) begin
      pc_d = pc_q + PC_INC;
    end
  end

  // PC register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign fetch_entry = '{instr: i_IMemInstr, pc: pc_q};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .flush     (redirect_en),
    .push      (fetch_en),
    .push_data (fetch_entry),
    .pop       (pop_req && !redirect_en),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign o_IMemAddr = pc_q;
  assign o_Valid    = (fifo_count != '0);
  assign o_Instr    = fifo_head.instr;
  assign o_PC       = fifo_head.pc;
  assign o_DbgState = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH = 2, RESET_PC = 0). An expected-PC queue
// is loaded whenever the bench starts a fetch stream; every transfer to decode
// pops it and compares o_PC and o_Instr.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         i_Clk;
  logic         i_Rst_n;
  logic [31:0]  o_IMemAddr;
  logic [31:0]  i_IMemInstr;
  logic         i_Redirect;
  logic [31:0]  i_RedirectPC;
  logic         o_Valid;
  logic         i_Ready;
  logic [31:0]  o_Instr;
  logic [31:0]  o_PC;
  logic         o_Misalign;
  fetch_state_e o_DbgState;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .o_IMemAddr   (o_IMemAddr),
    .i_IMemInstr  (i_IMemInstr),
    .i_Redirect   (i_Redirect),
    .i_RedirectPC (i_RedirectPC),
    .o_Valid      (o_Valid),
    .i_Ready      (i_Ready),
    .o_Instr      (o_Instr),
    .o_PC         (o_PC),
    .o_Misalign   (o_Misalign),
    .o_DbgState   (o_DbgState)
  );

  // Clock generation.
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Instruction memory model: word differs from its address so instr/pc mix-ups show.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign i_IMemInstr = mem_word(o_IMemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Load the expected stream start..start+4*(n-1) after discarding stale entries.
  task automatic load_stream(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Score any transfer happening at the next edge, then advance one cycle.
  task automatic tick();
    logic [31:0] e;
    if (i_Rst_n && !i_Redirect && o_Valid && i_Ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_empty observed pc=%h expected no transfer", o_PC);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", o_PC, e);
        chk("sb_instr", o_Instr, mem_word(e));
      end
    end
    @(posedge i_Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    i_Rst_n      = 1'b0;
    i_Ready      = 1'b0;
    i_Redirect   = 1'b0;
    i_RedirectPC = 32'h0;

    // Reset state.
    ticks(3);
    chk("rst_valid", 32'(o_Valid), 32'd0);
    chk("rst_addr", o_IMemAddr, 32'h0);
    chk("rst_misalign", 32'(o_Misalign), 32'd0);
    chk("rst_state", 32'(o_DbgState), 32'(ST_BOOT));

    // Release with decode always ready: 0, 4, 8 on consecutive cycles.
    i_Rst_n = 1'b1;
    i_Ready = 1'b1;
    load_stream(32'h0, 16);
    tick();
    chk("boot_valid", 32'(o_Valid), 32'd0);
    chk("boot_state", 32'(o_DbgState), 32'(ST_RUN));
    tick();
    chk("first_valid", 32'(o_Valid), 32'd1);
    chk("first_pc", o_PC, 32'h0);
    tick();
    chk("second_pc", o_PC, 32'h4);
    tick();
    chk("third_pc", o_PC, 32'h8);
    ticks(3);

    // Stall mid-stream: buffer fills, PC and head hold.
    i_Ready = 1'b0;
    ticks(5);
    chk("stall_valid", 32'(o_Valid), 32'd1);
    chk("stall_pc", o_PC, exp_q[0]);
    chk("stall_addr", o_IMemAddr, exp_q[0] + 32'h8);
    i_Ready = 1'b1;
    ticks(4);

    // Reset with o_Valid high discards everything.
    chk("pre_rst_valid", 32'(o_Valid), 32'd1);
    i_Rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(o_Valid), 32'd0);
    chk("midrst_addr", o_IMemAddr, 32'h0);

    // Restart with decode stalled: saturates at two entries, PC holds at 0x8.
    i_Rst_n = 1'b1;
    i_Ready = 1'b0;
    load_stream(32'h0, 16);
    ticks(7);
    chk("sat_valid", 32'(o_Valid), 32'd1);
    chk("sat_pc", o_PC, 32'h0);
    chk("sat_instr", o_Instr, mem_word(32'h0));
    chk("sat_addr", o_IMemAddr, 32'h8);
    i_Ready = 1'b1;
    ticks(6);

    // Redirect with two buffered entries while decode is ready.
    i_Ready = 1'b0;
    tick();
    i_Ready      = 1'b1;
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h100;
    tick();
    load_stream(32'h100, 8);
    i_Redirect = 1'b0;
    chk("redir_flush_valid", 32'(o_Valid), 32'd0);
    chk("redir_addr", o_IMemAddr, 32'h100);
    tick();
    chk("redir_valid", 32'(o_Valid), 32'd1);
    chk("redir_pc", o_PC, 32'h100);
    ticks(3);

    // Misaligned redirect target.
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h102;
    tick();
    i_Redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_q.delete();
    chk("mis_flag", 32'(o_Misalign), 32'd1);
    chk("mis_state", 32'(o_DbgState), 32'(ST_TRAP));
    ticks(3);
    chk("mis_no_fetch", 32'(o_Valid), 32'd0);
    chk("mis_addr_hold", o_IMemAddr, 32'h102);
    chk("mis_sticky", 32'(o_Misalign), 32'd1);
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h200;
    tick();
    i_Redirect = 1'b0;
    load_stream(32'h200, 8);
    chk("mis_clear", 32'(o_Misalign), 32'd0);
    tick();
    chk("mis_exit_pc", o_PC, 32'h200);
`else
    load_stream(32'h100, 8);
    chk("nomis_flag", 32'(o_Misalign), 32'd0);
    chk("nomis_addr", o_IMemAddr, 32'h100);
    tick();
    chk("nomis_pc", o_PC, 32'h100);
`endif
    ticks(3);

    // PC wraps from the top of the address space to zero.
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'hFFFF_FFFC;
    tick();
    i_Redirect = 1'b0;
    load_stream(32'hFFFF_FFFC, 8);
    tick();
    chk("wrap_top_pc", o_PC, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero_pc", o_PC, 32'h0);
    ticks(3);

    i_Ready = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
